// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: configurable serial pattern detector with a run controller.
//
// A pattern of 1..MAXLEN bits is loaded through a valid/ready handshake. A start
// request arms the detector. While it runs, each valid serial bit is shifted into a
// history register, and every match against the pattern is counted. The run stops
// when the match count reaches a programmable target, or when an abort arrives.
//
// Ports
//   clk            clock; all state changes on the rising edge
//   reset          asynchronous, active-high reset
//   cfg_valid_i    configuration request
//   cfg_ready_o    configuration accepted this cycle (any state except RUN)
//   cfg_pattern_i  pattern; bit [len-1] is the oldest bit, bit [0] is the newest
//   cfg_len_i      pattern length, legal range 1..MAXLEN
//   cfg_target_i   matches before auto-stop; 0 runs until abort
//   cfg_overlap_i  1 allows overlapping matches, 0 needs len fresh bits per match
//   start_i        arm request, honoured in READY/DONE
//   abort_i        stop request, honoured in RUN (wins over start_i)
//   din_i          serial data bit
//   din_valid_i    qualifies din_i
//   match_o        one-cycle pulse per detected pattern
//   match_count_o  matches since the last start
//   busy_o         high in RUN
//   done_o         high in DONE
//   cfg_err_o      one-cycle pulse after a rejected configuration
module seq_det_ctrl #(
  parameter int unsigned MAXLEN = 8,
  parameter int unsigned CNTW   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [MAXLEN-1:0] cfg_pattern_i,
  input  logic [3:0]        cfg_len_i,
  input  logic [CNTW-1:0]   cfg_target_i,
  input  logic              cfg_overlap_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              din_i,
  input  logic              din_valid_i,
  output logic              match_o,
  output logic [CNTW-1:0]   match_count_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              cfg_err_o
);

  localparam int unsigned FillW = $clog2(MAXLEN + 1);
  localparam int unsigned CmpW  = (FillW > 4) ? FillW : 4;

  typedef enum logic [1:0] {StIdle, StReady, StRun, StDone} state_e;

  state_e            state_q;
  logic [MAXLEN-1:0] pat_q;
  logic [3:0]        len_q;
  logic [CNTW-1:0]   tgt_q;
  logic              ovl_q;
  // Only MAXLEN-1 history bits are stored: the oldest bit of a full-length window is
  // needed solely in the cycle it is compared, where it comes from the shifted view.
  logic [MAXLEN-2:0] hist_q;
  logic [FillW-1:0]  fill_q;
  logic [CNTW-1:0]   cnt_q;
  logic              match_q;
  logic              cfg_err_q;

  logic [MAXLEN-1:0] hist_upd;
  logic [FillW-1:0]  fill_upd;
  logic [MAXLEN-1:0] len_mask;
  logic [CNTW-1:0]   cnt_upd;
  logic              hit;
  logic              cfg_ok;

  always_comb begin
    hist_upd = {hist_q, din_i};
    fill_upd = (fill_q == FillW'(MAXLEN)) ? fill_q : fill_q + FillW'(1);
    // len == MAXLEN wraps the shift to zero, giving an all-ones mask.
    len_mask = (MAXLEN'(1) << len_q) - MAXLEN'(1);
    hit      = din_valid_i && (CmpW'(fill_upd) >= CmpW'(len_q)) &&
               ((hist_upd & len_mask) == (pat_q & len_mask));
    // With no target the count saturates; with a target the run stops first.
    cnt_upd  = ((tgt_q == '0) && (cnt_q == '1)) ? cnt_q : cnt_q + CNTW'(1);
    cfg_ok   = (cfg_len_i != 4'd0) && (32'(cfg_len_i) <= MAXLEN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      pat_q     <= '0;
      len_q     <= '0;
      tgt_q     <= '0;
      ovl_q     <= 1'b0;
      hist_q    <= '0;
      fill_q    <= '0;
      cnt_q     <= '0;
      match_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      match_q   <= 1'b0;
      cfg_err_q <= 1'b0;
      case (state_q)
        StIdle, StReady, StDone: begin
          if (cfg_valid_i) begin
            if (cfg_ok) begin
              pat_q   <= cfg_pattern_i;
              len_q   <= cfg_len_i;
              tgt_q   <= cfg_target_i;
              ovl_q   <= cfg_overlap_i;
              state_q <= StReady;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
          // Placed after the config branch so an accepted start takes precedence.
          if (start_i && (state_q != StIdle)) begin
            state_q <= StRun;
            cnt_q   <= '0;
            hist_q  <= '0;
            fill_q  <= '0;
          end
        end
        StRun: begin
          if (din_valid_i) begin
            hist_q <= hist_upd[MAXLEN-2:0];
            fill_q <= fill_upd;
            if (hit) begin
              match_q <= 1'b1;
              cnt_q   <= cnt_upd;
              if (!ovl_q) begin
                fill_q <= '0;
                hist_q <= '0;
              end
              if ((tgt_q != '0) && (cnt_upd == tgt_q)) begin
                state_q <= StDone;
              end
            end
          end
          // A match on the abort sample is still counted above; abort sets the state.
          if (abort_i) begin
            state_q <= StReady;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cfg_ready_o   = (state_q != StRun);
  assign busy_o        = (state_q == StRun);
  assign done_o        = (state_q == StDone);
  assign match_o       = match_q;
  assign match_count_o = cnt_q;
  assign cfg_err_o     = cfg_err_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: directed scenarios plus a randomized run against a
// queue-based reference model of the detector's rules.
module tb_seq_det_ctrl;

  localparam int unsigned MAXLEN = 8;
  localparam int unsigned CNTW   = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [MAXLEN-1:0] cfg_pattern;
  logic [3:0]        cfg_len;
  logic [CNTW-1:0]   cfg_target;
  logic              cfg_overlap;
  logic              start;
  logic              abort;
  logic              din;
  logic              din_valid;
  logic              match;
  logic [CNTW-1:0]   match_count;
  logic              busy;
  logic              done;
  logic              cfg_err;

  int checks = 0;
  int errors = 0;

  seq_det_ctrl #(.MAXLEN(MAXLEN), .CNTW(CNTW)) dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_valid_i   (cfg_valid),
    .cfg_ready_o   (cfg_ready),
    .cfg_pattern_i (cfg_pattern),
    .cfg_len_i     (cfg_len),
    .cfg_target_i  (cfg_target),
    .cfg_overlap_i (cfg_overlap),
    .start_i       (start),
    .abort_i       (abort),
    .din_i         (din),
    .din_valid_i   (din_valid),
    .match_o       (match),
    .match_count_o (match_count),
    .busy_o        (busy),
    .done_o        (done),
    .cfg_err_o     (cfg_err)
  );

  always #5 clk = ~clk;

  // Reference model: the bits seen since the last start (or non-overlapping match)
  // are kept in a queue, and a match is a tail comparison against the pattern.
  typedef enum int {MIdle, MReady, MRun, MDone} mst_e;
  mst_e              m_st;
  bit                m_bits[$];
  logic [MAXLEN-1:0] m_pat;
  int                m_len;
  int                m_tgt;
  bit                m_ovl;
  int                m_cnt;
  bit                e_match;
  bit                e_err;

  task automatic model_reset();
    m_st = MIdle;
    m_bits.delete();
    m_pat = '0;
    m_len = 0;
    m_tgt = 0;
    m_ovl = 0;
    m_cnt = 0;
    e_match = 0;
    e_err = 0;
  endtask

  task automatic model_step();
    mst_e nxt;
    bit   hit;
    int   n;
    nxt = m_st;
    e_match = 0;
    e_err = 0;
    if (m_st != MRun) begin
      if (cfg_valid) begin
        if (cfg_len >= 1 && cfg_len <= MAXLEN) begin
          m_pat = cfg_pattern;
          m_len = int'(cfg_len);
          m_tgt = int'(cfg_target);
          m_ovl = cfg_overlap;
          nxt = MReady;
        end else begin
          e_err = 1;
        end
      end
      if (start && m_st != MIdle) begin
        nxt = MRun;
        m_cnt = 0;
        m_bits.delete();
      end
    end else begin
      if (din_valid) begin
        m_bits.push_back(din);
        if (m_bits.size() > MAXLEN) void'(m_bits.pop_front());
        n = m_bits.size();
        hit = (n >= m_len);
        for (int i = 0; i < m_len; i++) begin
          if (hit && (m_bits[n - 1 - i] != m_pat[i])) hit = 0;
        end
        if (hit) begin
          e_match = 1;
          if (m_tgt == 0) begin
            if (m_cnt < (1 << CNTW) - 1) m_cnt++;
          end else begin
            m_cnt++;
          end
          if (!m_ovl) m_bits.delete();
          if (m_tgt != 0 && m_cnt == m_tgt) nxt = MDone;
        end
      end
      if (abort) nxt = MReady;
    end
    m_st = nxt;
  endtask

  // Advance one clock with the model tracking the same inputs; outputs settle by #1.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cfg_valid = 0;
    cfg_pattern = '0;
    cfg_len = '0;
    cfg_target = '0;
    cfg_overlap = 0;
    start = 0;
    abort = 0;
    din = 0;
    din_valid = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  task automatic configure(input logic [MAXLEN-1:0] pat, input logic [3:0] len,
                           input logic [CNTW-1:0] tgt, input logic ovl);
    cfg_valid = 1;
    cfg_pattern = pat;
    cfg_len = len;
    cfg_target = tgt;
    cfg_overlap = ovl;
    step();
    cfg_valid = 0;
  endtask

  task automatic arm();
    start = 1;
    step();
    start = 0;
  endtask

  task automatic test_reset();
    do_reset();
    if ({match, busy, done, cfg_err, cfg_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_flags got %b exp 00001", {match, busy, done, cfg_err, cfg_ready});
    end
    checks++;
    if (match_count !== '0) begin
      errors++;
      $display("FAIL reset_count got %0d exp 0", match_count);
    end
    checks++;
    din = 1;
    din_valid = 1;
    step();
    step();
    din_valid = 0;
    if (match !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_din match %b busy %b exp 0 0", match, busy);
    end
    checks++;
  endtask

  task automatic test_overlap();
    logic [9:0] s;
    s = 10'b1100110011;
    do_reset();
    configure(8'b0011_0011, 4'd6, '0, 1'b1);
    if (busy !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL ovl_ready busy %b ready %b exp 0 1", busy, cfg_ready);
    end
    checks++;
    arm();
    if (busy !== 1'b1 || cfg_ready !== 1'b0 || match_count !== '0) begin
      errors++;
      $display("FAIL ovl_run busy %b ready %b cnt %0d exp 1 0 0", busy, cfg_ready, match_count);
    end
    checks++;
    for (int i = 0; i < 10; i++) begin
      din = s[9 - i];
      din_valid = 1;
      step();
      if (match !== ((i == 5) || (i == 9))) begin
        errors++;
        $display("FAIL ovl_match bit %0d got %b", i + 1, match);
      end
      checks++;
    end
    din_valid = 0;
    if (match_count !== 8'd2) begin
      errors++;
      $display("FAIL ovl_count got %0d exp 2", match_count);
    end
    checks++;
  endtask

  task automatic test_no_overlap();
    logic [9:0] s;
    s = 10'b1100110011;
    do_reset();
    configure(8'b0011_0011, 4'd6, '0, 1'b0);
    arm();
    for (int i = 0; i < 10; i++) begin
      din = s[9 - i];
      din_valid = 1;
      step();
      if (match !== (i == 5)) begin
        errors++;
        $display("FAIL novl_match bit %0d got %b", i + 1, match);
      end
      checks++;
    end
    din_valid = 0;
    if (match_count !== 8'd1) begin
      errors++;
      $display("FAIL novl_count got %0d exp 1", match_count);
    end
    checks++;
  endtask

  task automatic test_target();
    logic [11:0] s;
    s = 12'b1100_1111_0011;
    do_reset();
    configure(8'b0011_0011, 4'd6, 8'd2, 1'b0);
    arm();
    for (int i = 0; i < 12; i++) begin
      din = s[11 - i];
      din_valid = 1;
      step();
      if (match !== ((i == 5) || (i == 11))) begin
        errors++;
        $display("FAIL tgt_match bit %0d got %b", i + 1, match);
      end
      checks++;
    end
    if ({busy, done, cfg_ready} !== 3'b011 || match_count !== 8'd2) begin
      errors++;
      $display("FAIL tgt_done busy/done/ready %b cnt %0d exp 011 2",
               {busy, done, cfg_ready}, match_count);
    end
    checks++;
    for (int i = 0; i < 6; i++) begin
      din = s[11 - i];
      din_valid = 1;
      step();
      if (match !== 1'b0) begin
        errors++;
        $display("FAIL tgt_ignore bit %0d got %b exp 0", i + 1, match);
      end
      checks++;
    end
    din_valid = 0;
    if (match_count !== 8'd2 || done !== 1'b1) begin
      errors++;
      $display("FAIL tgt_hold cnt %0d done %b exp 2 1", match_count, done);
    end
    checks++;
  endtask

  task automatic test_cfg_err();
    do_reset();
    configure(8'hA5, 4'd0, 8'd1, 1'b1);
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL err_len0 got %b exp 1", cfg_err);
    end
    checks++;
    step();
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse got %b exp 0", cfg_err);
    end
    checks++;
    configure(8'hA5, 4'd9, 8'd1, 1'b1);
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL err_len9 got %b exp 1", cfg_err);
    end
    checks++;
    arm();
    if ({busy, done, cfg_ready, cfg_err} !== 4'b0010) begin
      errors++;
      $display("FAIL err_idle busy/done/ready/err %b exp 0010", {busy, done, cfg_ready, cfg_err});
    end
    checks++;
  endtask

  task automatic test_abort();
    logic [5:0] s;
    s = 6'b110011;
    do_reset();
    configure(8'b0011_0011, 4'd6, '0, 1'b1);
    arm();
    for (int i = 0; i < 6; i++) begin
      din = s[5 - i];
      din_valid = 1;
      abort = (i == 5);
      step();
    end
    abort = 0;
    din_valid = 0;
    if ({match, busy, done, cfg_ready} !== 4'b1001 || match_count !== 8'd1) begin
      errors++;
      $display("FAIL abort_match match/busy/done/ready %b cnt %0d exp 1001 1",
               {match, busy, done, cfg_ready}, match_count);
    end
    checks++;
    din_valid = 1;
    din = 1;
    step();
    din_valid = 0;
    if (match !== 1'b0 || match_count !== 8'd1) begin
      errors++;
      $display("FAIL abort_retain match %b cnt %0d exp 0 1", match, match_count);
    end
    checks++;
    arm();
    if (busy !== 1'b1 || match_count !== '0) begin
      errors++;
      $display("FAIL abort_rearm busy %b cnt %0d exp 1 0", busy, match_count);
    end
    checks++;
    start = 1;
    abort = 1;
    step();
    start = 0;
    abort = 0;
    if ({busy, done, cfg_ready} !== 3'b001) begin
      errors++;
      $display("FAIL abort_start busy/done/ready %b exp 001", {busy, done, cfg_ready});
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    logic [6:0] s;
    s = 7'b1100110;
    do_reset();
    configure(8'b0011_0011, 4'd6, '0, 1'b1);
    arm();
    for (int i = 0; i < 7; i++) begin
      din = s[6 - i];
      din_valid = 1;
      step();
    end
    if (match_count !== 8'd1) begin
      errors++;
      $display("FAIL mid_precount got %0d exp 1", match_count);
    end
    checks++;
    #2;
    reset = 1;
    model_reset();
    #1;
    if ({match, busy, done, cfg_err, cfg_ready} !== 5'b00001 || match_count !== '0) begin
      errors++;
      $display("FAIL mid_reset flags %b cnt %0d exp 00001 0",
               {match, busy, done, cfg_err, cfg_ready}, match_count);
    end
    checks++;
    @(posedge clk);
    #1;
    reset = 0;
    din_valid = 0;
    arm();
    if (busy !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_start busy %b ready %b exp 0 1", busy, cfg_ready);
    end
    checks++;
  endtask

  task automatic test_saturate();
    do_reset();
    configure(8'b0000_0001, 4'd1, '0, 1'b1);
    arm();
    din = 1;
    din_valid = 1;
    for (int i = 0; i < 260; i++) step();
    din_valid = 0;
    if (match !== 1'b1 || match_count !== 8'hFF || busy !== 1'b1) begin
      errors++;
      $display("FAIL sat match %b cnt %0d busy %b exp 1 255 1", match, match_count, busy);
    end
    checks++;
  endtask

  task automatic test_random();
    logic [CNTW+4:0] got;
    logic [CNTW+4:0] exp;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      cfg_valid = ($urandom_range(0, 11) == 0);
      cfg_pattern = MAXLEN'($urandom);
      if ($urandom_range(0, 9) == 0) cfg_len = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(9, 15));
      else if ($urandom_range(0, 1) == 0) cfg_len = 4'($urandom_range(1, 3));
      else cfg_len = 4'($urandom_range(1, MAXLEN));
      cfg_target = CNTW'($urandom_range(0, 4));
      cfg_overlap = 1'($urandom_range(0, 1));
      start = !cfg_valid && ($urandom_range(0, 15) == 0);
      abort = ($urandom_range(0, 39) == 0);
      din = 1'($urandom_range(0, 1));
      din_valid = ($urandom_range(0, 3) != 0);
      step();
      got = {match, cfg_err, busy, done, cfg_ready, match_count};
      exp = {e_match, e_err, m_st == MRun, m_st == MDone, m_st != MRun, CNTW'(m_cnt)};
      if (got !== exp) begin
        errors++;
        $display("FAIL rnd cyc %0d match/err/busy/done/ready/cnt got %b exp %b", c, got, exp);
      end
      checks++;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    test_reset();
    test_overlap();
    test_no_overlap();
    test_target();
    test_cfg_err();
    test_abort();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 Parameter MAXLEN, default 8, maximum pattern length in bits.
REQ-002 Parameter CNTW, default 8, width of match counter and target.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cfg_valid  input  1  configuration request.
REQ-006 cfg_ready  output  1  controller accepts configuration this cycle.
REQ-007 cfg_pattern  input  MAXLEN  pattern bits; bit [cfg_len-1] is the oldest bit, bit [0] is the newest.
REQ-008 cfg_len  input  4  pattern length; valid range 1..MAXLEN.
REQ-009 cfg_target  input  CNTW  number of matches before auto-stop; 0 = run until abort.
REQ-010 cfg_overlap  input  1  1 = overlapping matches allowed; 0 = history cleared after each match.
REQ-011 start  input  1  single-cycle arm request.
REQ-012 abort  input  1  single-cycle stop request.
REQ-013 din  input  1  serial data bit.
REQ-014 din_valid  input  1  din is sampled only when high.
REQ-015 match  output  1  one-cycle pulse per detected pattern.
REQ-016 match_count  output  CNTW  matches detected since the last start.
REQ-017 busy  output  1  high in RUN.
REQ-018 done  output  1  high in DONE.
REQ-019 cfg_err  output  1  one-cycle pulse on a rejected configuration.

Function
REQ-020 The FSM SHALL have states IDLE (unconfigured), READY (configured), RUN and DONE.
REQ-021 cfg_ready SHALL equal 1 in IDLE, READY and DONE, and 0 in RUN.
REQ-022 A handshake (cfg_valid & cfg_ready) with cfg_len in 1..MAXLEN SHALL latch pattern, len, target and overlap, and move to READY.
REQ-023 A handshake with cfg_len 0 or cfg_len > MAXLEN SHALL pulse cfg_err the next cycle, leave the stored config unchanged, and leave the state unchanged.
REQ-024 start in READY or DONE SHALL enter RUN, clear match_count, clear the history shift register, and clear the fill counter.
REQ-025 start in IDLE or RUN SHALL be ignored.
REQ-026 In RUN, each din_valid cycle SHALL shift din into the history register LSB and increment the fill counter, saturating at MAXLEN.
REQ-027 A match SHALL occur when fill >= len and history[len-1:0] == pattern[len-1:0], evaluated on the updated history.
REQ-028 match SHALL pulse in the cycle after the din_valid sample that completes the pattern (1-cycle latency); match_count SHALL update in the same cycle as the pulse.
REQ-029 With cfg_overlap = 0, a match SHALL reset the fill counter to 0, so the next match needs len fresh bits.
REQ-030 With cfg_overlap = 1, the fill counter SHALL be unaffected by a match.
REQ-031 When target != 0 and the increment makes match_count == target, the FSM SHALL enter DONE in the same cycle as the final match pulse.
REQ-032 When target == 0, match_count SHALL saturate at all-ones.
REQ-033 abort in RUN SHALL return the FSM to READY and retain match_count; a match completing on the abort sample SHALL still be counted and pulsed.
REQ-034 abort and start asserted in the same cycle: abort SHALL win, start SHALL be ignored.
REQ-035 din_valid low SHALL leave the history and fill counter unchanged.
REQ-036 Outside RUN, din SHALL be ignored and match SHALL be 0.

Reset
REQ-037 reset SHALL force state IDLE, history 0, fill 0, stored config 0, and match = match_count = busy = done = cfg_err = 0.
REQ-038 reset SHALL drive cfg_ready = 1, since the state is IDLE.
REQ-039 reset asserted mid-RUN SHALL discard all progress, including the configuration.

Verification
REQ-040 Config pattern 6'b110011, len 6, overlap 1, target 0; start; stream 1100110011 -> match pulses after bits 6 and 10; match_count = 2.
REQ-041 Same stream with overlap 0 -> single match after bit 6; match_count = 1.
REQ-042 Target 2 with the stream 110011110011 -> DONE after the second match; busy = 0, done = 1; further din is ignored.
REQ-043 cfg_len = 0, then cfg_len = 9 -> cfg_err pulses twice; the FSM stays in IDLE; start has no effect.
REQ-044 Abort asserted on the bit completing a match -> match pulses, match_count = 1, FSM in READY; simultaneous start + abort in RUN -> READY.
REQ-045 Reset asserted mid-stream -> all outputs 0, cfg_ready = 1, state IDLE; start without reconfiguration is ignored.
